// File: rtl/cam_pkg.sv
// Shared camera-path definitions.
// Holds the capture FSM state encoding, the RGB565 pixel layout and the
// default frame geometry reused by the LCD timing and DDR address blocks.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        WAIT_VS,
        ACTIVE
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;

    // Counter width able to hold n plus one spare bit, so an overrun is visible.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/cmos_byte_packer.sv
// Byte-to-word packer for the camera capture path.
// Assembles four sensor bytes (two RGB565 pixels) into one 32-bit word and
// strobes it out, tracks the byte count of each line and flags bad lines.
//
// Ports:
//   clk       pixel clock
//   rst_n     asynchronous active-low reset
//   active    packing enabled (capture FSM in ACTIVE)
//   clr_cnt   frame start: clear byte phase and byte counter
//   clr_err   capture re-enabled: clear the sticky line_err
//   href      registered line-valid
//   data      registered sensor byte
//   wrreq     one-cycle strobe per packed word
//   din       packed word {pixel0, pixel1}, held between strobes
//   line_end  combinational pulse on the href falling edge while active
//   line_err  sticky: some line byte count differed from 2*H_PIXELS
module cmos_byte_packer
    import cam_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        clr_cnt,
    input  logic        clr_err,
    input  logic        href,
    input  logic [7:0]  data,
    output logic        wrreq,
    output logic [31:0] din,
    output logic        line_end,
    output logic        line_err
);

    localparam int BW = cnt_width(2 * H_PIXELS);

    logic          href_d;
    logic [1:0]    phase;
    logic [23:0]   acc;
    logic [BW-1:0] byte_cnt;
    rgb565_t       pix0;
    rgb565_t       pix1;

    assign line_end = active & href_d & ~href;
    assign pix0     = acc[23:8];
    assign pix1     = {acc[7:0], data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d   <= 1'b0;
            phase    <= 2'd0;
            acc      <= '0;
            byte_cnt <= '0;
            wrreq    <= 1'b0;
            din      <= '0;
            line_err <= 1'b0;
        end else begin
            href_d <= href;
            wrreq  <= 1'b0;
            if (clr_err) begin
                line_err <= 1'b0;
            end
            if (clr_cnt) begin
                phase    <= 2'd0;
                byte_cnt <= '0;
            end else if (active) begin
                if (href) begin
                    case (phase)
                        2'd0: acc[23:16] <= data;
                        2'd1: acc[15:8]  <= data;
                        2'd2: acc[7:0]   <= data;
                        default: begin
                            din   <= {pix0, pix1};
                            wrreq <= 1'b1;
                        end
                    endcase
                    phase <= phase + 2'd1;
                    // Saturate so a runaway line cannot wrap back to a "good" count.
                    if (byte_cnt != '1) begin
                        byte_cnt <= byte_cnt + BW'(1);
                    end
                end else if (href_d) begin
                    // Line end: any partial word is simply abandoned.
                    phase    <= 2'd0;
                    byte_cnt <= '0;
                    if (byte_cnt != BW'(2 * H_PIXELS)) begin
                        line_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cmos_capture_pack.sv
// OV7670 capture stage in the cmos_pclk domain, feeding the DDR write FIFO.
// Registers the sensor bus, skips settling frames, packs two RGB565 pixels
// per 32-bit word and frames each captured image for the FIFO controller.
//
// Ports:
//   cmos_pclk      pixel clock, all logic on its rising edge
//   rst_n          asynchronous active-low reset
//   cmos_vsync     sensor vsync, high during vertical blanking
//   cmos_href      sensor line-valid
//   cmos_data      sensor data byte
//   capture_en     capture enable (level)
//   wrf_wrreq      FIFO write strobe, one cycle per word
//   wrf_din        packed word {pixel0, pixel1}
//   data_valid_wr  frame write window; low clears FIFO / rewinds address
//   wr_load        base-address load pulse at frame start
//   frame_done     one-cycle pulse at the end of each captured frame
//   line_err       sticky bad-line flag
//   frame_err      sticky bad-frame flag
//   frame_cnt      captured frame count, wrapping
module cmos_capture_pack
    import cam_pkg::*;
#(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int LOAD_CYCLES = 4
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        capture_en,
    output logic        wrf_wrreq,
    output logic [31:0] wrf_din,
    output logic        data_valid_wr,
    output logic        wr_load,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam int LW  = cnt_width(V_LINES);
    localparam int SW  = cnt_width(SKIP_FRAMES + 1);
    localparam int LDW = cnt_width(LOAD_CYCLES);

    cap_state_t     state;
    logic           vs_s1, vs_s2, href_s1;
    logic [7:0]     data_s1;
    logic           cap_d;
    logic [SW-1:0]  skip_cnt;
    logic [LDW-1:0] load_cnt;
    logic [LW-1:0]  line_cnt;
    logic           vs_fall, vs_rise, cap_rise, line_end;

    assign vs_fall  = vs_s2 & ~vs_s1;
    assign vs_rise  = ~vs_s2 & vs_s1;
    assign cap_rise = capture_en & ~cap_d;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            href_s1 <= 1'b0;
            data_s1 <= '0;
        end else begin
            vs_s1   <= cmos_vsync;
            vs_s2   <= vs_s1;
            href_s1 <= cmos_href;
            data_s1 <= cmos_data;
        end
    end

    cmos_byte_packer #(
        .H_PIXELS (H_PIXELS)
    ) u_packer (
        .clk      (cmos_pclk),
        .rst_n    (rst_n),
        .active   (state == ACTIVE),
        .clr_cnt  (vs_fall),
        .clr_err  (cap_rise),
        .href     (href_s1),
        .data     (data_s1),
        .wrreq    (wrf_wrreq),
        .din      (wrf_din),
        .line_end (line_end),
        .line_err (line_err)
    );

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cap_d         <= 1'b0;
            skip_cnt      <= '0;
            load_cnt      <= '0;
            line_cnt      <= '0;
            data_valid_wr <= 1'b0;
            wr_load       <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            cap_d      <= capture_en;
            frame_done <= 1'b0;
            if (cap_rise) begin
                frame_err <= 1'b0;
            end

            // wr_load stretch: held while load_cnt counts down to zero.
            if (load_cnt != '0) begin
                load_cnt <= load_cnt - LDW'(1);
            end else begin
                wr_load <= 1'b0;
            end

            if (vs_fall) begin
                line_cnt <= '0;
            end else if (line_end) begin
                if (line_cnt == '1) begin
                    frame_err <= 1'b1;
                end else begin
                    line_cnt <= line_cnt + LW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (capture_en) begin
                        skip_cnt <= '0;
                        state    <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
                    end
                end
                SKIP: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        skip_cnt <= skip_cnt + SW'(1);
                        if (skip_cnt + SW'(1) >= SW'(SKIP_FRAMES)) begin
                            state <= WAIT_VS;
                        end
                    end
                end
                WAIT_VS: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        state         <= ACTIVE;
                        data_valid_wr <= 1'b1;
                        wr_load       <= 1'b1;
                        load_cnt      <= LDW'(LOAD_CYCLES - 1);
                    end
                end
                default: begin
                    // A frame in progress always runs to vsync; capture_en is
                    // only honoured at the frame boundary.
                    if (vs_rise) begin
                        data_valid_wr <= 1'b0;
                        frame_done    <= 1'b1;
                        frame_cnt     <= frame_cnt + 8'd1;
                        if (line_cnt != LW'(V_LINES)) begin
                            frame_err <= 1'b1;
                        end
                        state <= capture_en ? WAIT_VS : IDLE;
                    end
                end
            endcase
        end
    end

endmodule
